// File: rtl/generic_bus_manager.sv
// GenericBus manager: takes a command plus write-data stream, issues single or
// burst beats on the bus honouring busy, and returns one response per beat.
module generic_bus_manager #(
  parameter int DataWidth = 32,
  parameter int AddrWidth = 32,
  parameter int ProtWidth = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_write,
  input  logic [AddrWidth-1:0]   cmd_addr,
  input  logic [1:0]             cmd_burstType,
  input  logic [7:0]             cmd_burstLen,
  input  logic                   cmd_nonSec,
  input  logic [ProtWidth-1:0]   cmd_prot,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [DataWidth-1:0]   wr_data,
  input  logic [DataWidth/8-1:0] wr_strb,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [DataWidth-1:0]   rsp_rData,
  output logic                   rsp_error,
  output logic                   rsp_last,
  output logic                   bus_wEn,
  output logic                   bus_rEn,
  output logic [AddrWidth-1:0]   bus_addr,
  output logic [DataWidth-1:0]   bus_wData,
  output logic [DataWidth/8-1:0] bus_wStrb,
  output logic                   bus_isBurst,
  output logic [1:0]             bus_burstType,
  output logic [7:0]             bus_burstLen,
  output logic                   bus_nonSec,
  output logic [ProtWidth-1:0]   bus_prot,
  input  logic [DataWidth-1:0]   bus_rData,
  input  logic                   bus_error,
  input  logic                   bus_busy
);

  localparam int StrbWidth = DataWidth / 8;
  localparam logic [AddrWidth-1:0] BeatBytes = AddrWidth'(StrbWidth);

  typedef enum logic [1:0] {IDLE = 2'd0, ACTIVE = 2'd1, DRAIN = 2'd2} state_e;

  state_e     state, state_nxt;
  logic       write_q;
  logic [7:0] beats_left;
  logic       issued;
  logic       data_full;

  logic cmd_fire, wr_fire, rsp_fire;
  logic beat_done, final_beat, issue;

  assign cmd_fire   = cmd_valid && cmd_ready;
  assign wr_fire    = wr_valid && wr_ready;
  assign rsp_fire   = rsp_valid && rsp_ready;
  assign beat_done  = issued && !bus_busy;
  assign final_beat = beat_done && ((beats_left == 8'd0) || bus_error);
  // Issue only when the response slot is free by the completion edge.
  assign issue      = (state == ACTIVE) && !issued && (!rsp_valid || rsp_ready) &&
                      (!write_q || data_full);

  function automatic logic [AddrWidth-1:0] step_addr(
    input logic [AddrWidth-1:0] a,
    input logic [1:0]           bt,
    input logic [7:0]           len
  );
    logic [AddrWidth-1:0] inc, wsz, mask;
    logic                 wrap_ok;
    inc     = a + BeatBytes;
    wsz     = AddrWidth'((32'(len) + 32'd1) * 32'(StrbWidth));
    mask    = wsz - AddrWidth'(1);
    wrap_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    case (bt)
      2'd0:    step_addr = a;
      2'd2:    step_addr = wrap_ok ? ((a & ~mask) | (inc & mask)) : inc;
      default: step_addr = inc;
    endcase
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // The final response always lands in the response register, so the last
  // beat moves to DRAIN and the command port reopens only after it is taken.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cmd_fire)   state_nxt = ACTIVE;
      ACTIVE:  if (final_beat) state_nxt = DRAIN;
      DRAIN:   if (rsp_fire)   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state == IDLE) && !reset;
    wr_ready  = (state == ACTIVE) && write_q && !data_full;
    bus_wEn   = issued && write_q;
    bus_rEn   = issued && !write_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      write_q       <= 1'b0;
      beats_left    <= 8'd0;
      bus_addr      <= '0;
      bus_isBurst   <= 1'b0;
      bus_burstType <= 2'd0;
      bus_burstLen  <= 8'd0;
      bus_nonSec    <= 1'b0;
      bus_prot      <= '0;
    end else if (cmd_fire) begin
      write_q       <= cmd_write;
      beats_left    <= cmd_burstLen;
      bus_addr      <= cmd_addr;
      bus_isBurst   <= (cmd_burstLen != 8'd0);
      bus_burstType <= cmd_burstType;
      bus_burstLen  <= cmd_burstLen;
      bus_nonSec    <= cmd_nonSec;
      bus_prot      <= cmd_prot;
    end else if (beat_done) begin
      beats_left    <= beats_left - 8'd1;
      bus_addr      <= step_addr(bus_addr, bus_burstType, bus_burstLen);
    end
  end

  // The write-data register drives the bus payload directly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_full <= 1'b0;
      bus_wData <= '0;
      bus_wStrb <= '0;
    end else if (wr_fire) begin
      data_full <= 1'b1;
      bus_wData <= wr_data;
      bus_wStrb <= wr_strb;
    end else if (beat_done) begin
      data_full <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)          issued <= 1'b0;
    else if (beat_done) issued <= 1'b0;
    else if (issue)     issued <= 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid <= 1'b0;
      rsp_rData <= '0;
      rsp_error <= 1'b0;
      rsp_last  <= 1'b0;
    end else if (beat_done) begin
      rsp_valid <= 1'b1;
      rsp_rData <= write_q ? '0 : bus_rData;
      rsp_error <= bus_error;
      rsp_last  <= (beats_left == 8'd0) || bus_error;
    end else if (rsp_fire) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_generic_bus_manager.sv
// Random and directed stimulus for generic_bus_manager, checked every cycle
// against a transaction-level model of beats, responses and handshakes.
module tb_generic_bus_manager;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready, cmd_write, cmd_nonSec;
  logic [31:0] cmd_addr;
  logic [1:0]  cmd_burstType;
  logic [7:0]  cmd_burstLen;
  logic [3:0]  cmd_prot;
  logic        wr_valid, wr_ready;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;
  logic        rsp_valid, rsp_ready, rsp_error, rsp_last;
  logic [31:0] rsp_rData;
  logic        bus_wEn, bus_rEn, bus_isBurst, bus_nonSec;
  logic [31:0] bus_addr, bus_wData, bus_rData;
  logic [3:0]  bus_wStrb, bus_prot;
  logic [1:0]  bus_burstType;
  logic [7:0]  bus_burstLen;
  logic        bus_error, bus_busy;

  generic_bus_manager dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_burstType(cmd_burstType), .cmd_burstLen(cmd_burstLen),
    .cmd_nonSec(cmd_nonSec), .cmd_prot(cmd_prot),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_strb(wr_strb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rData(rsp_rData),
    .rsp_error(rsp_error), .rsp_last(rsp_last),
    .bus_wEn(bus_wEn), .bus_rEn(bus_rEn), .bus_addr(bus_addr), .bus_wData(bus_wData),
    .bus_wStrb(bus_wStrb), .bus_isBurst(bus_isBurst), .bus_burstType(bus_burstType),
    .bus_burstLen(bus_burstLen), .bus_nonSec(bus_nonSec), .bus_prot(bus_prot),
    .bus_rData(bus_rData), .bus_error(bus_error), .bus_busy(bus_busy)
  );

  always #5 clk = ~clk;

  typedef struct {logic [31:0] addr; logic [31:0] wdata; logic [3:0] wstrb;} beat_t;
  typedef struct {logic [31:0] rdata; logic error; logic last;} rsp_t;

  int vectors = 0, miscompares = 0;
  beat_t exp_beats[$];
  beat_t wr_plan[$];
  rsp_t  exp_rsp[$];
  logic [31:0] addr_log[$];

  logic       cur_write, cur_ns;
  logic [1:0] cur_bt;
  logic [7:0] cur_len;
  logic [3:0] cur_prot;
  bit   txn_open = 0, errored = 0, wdata_fixed = 0, rdata_fixed = 0;
  int   beats_done = 0, wr_acc = 0, en_cycles = 0, rsp_cnt = 0, last_cnt = 0;
  int   err_beat = -1, busy_mode = 0, rdy_mode = 1, busy_held = 0;
  logic last_err = 0;
  logic [31:0] rdata_fix = 0;
  rsp_t r, e;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Address of beat i from first principles: wrap inside an aligned window.
  function automatic logic [31:0] model_addr(input logic [31:0] a, input logic [1:0] bt,
                                             input logic [7:0] len, input int i);
    longint unsigned w, base, aa;
    aa = a;
    if (bt == 2'd0) return a;
    if (bt == 2'd2 && (len == 1 || len == 3 || len == 7 || len == 15)) begin
      w    = (longint'(len) + 1) * 4;
      base = aa - (aa % w);
      return 32'(base + (aa - base + longint'(i) * 4) % w);
    end
    return 32'(aa + longint'(i) * 4);
  endfunction

  // Subordinate and response-consumer behaviour, updated just after each edge.
  initial begin
    bus_busy = 0; bus_error = 0; bus_rData = 0; rsp_ready = 0;
    forever begin
      @(posedge clk); #1;
      case (busy_mode)
        0: bus_busy = 1'b0;
        1: bus_busy = ($urandom_range(0, 2) == 0);
        default: begin
          if (bus_wEn || bus_rEn) begin bus_busy = (busy_held < 2); busy_held++; end
          else begin bus_busy = 1'b0; busy_held = 0; end
        end
      endcase
      bus_rData = rdata_fixed ? rdata_fix : $urandom;
      bus_error = (err_beat >= 0) && (beats_done == err_beat);
      rsp_ready = (rdy_mode == 0) ? 1'b0 : (rdy_mode == 1) ? 1'b1 : ($urandom_range(0, 9) < 7);
    end
  end

  // Compare process: every cycle, DUT outputs against the transaction model.
  always @(negedge clk) begin
    if (reset) begin
      exp_beats.delete(); exp_rsp.delete(); txn_open = 0;
    end else begin
      chk("cmd_ready", cmd_ready, !txn_open);
      chk("rsp_valid", rsp_valid, exp_rsp.size() != 0);
      chk("wr_ready", wr_ready,
          txn_open && cur_write && !errored && wr_acc == beats_done && wr_acc <= int'(cur_len));
      if (cmd_valid && cmd_ready) begin
        txn_open = 1; beats_done = 0; wr_acc = 0; errored = 0;
      end
      if (wr_valid && wr_ready) wr_acc++;
      if (bus_wEn || bus_rEn) begin
        en_cycles++;
        chk("bus_dir", {bus_wEn, bus_rEn}, {cur_write, !cur_write});
        chk("bus_attr", {bus_isBurst, bus_burstType, bus_burstLen, bus_nonSec, bus_prot},
            {cur_len != 8'd0, cur_bt, cur_len, cur_ns, cur_prot});
        if (exp_beats.size() == 0) chk("beat_overrun", 1, 0);
        else begin
          chk("bus_addr", bus_addr, exp_beats[0].addr);
          if (cur_write)
            chk("bus_wdata", {bus_wStrb, bus_wData}, {exp_beats[0].wstrb, exp_beats[0].wdata});
          if (!bus_busy) begin
            chk("rsp_overflow", rsp_valid && !rsp_ready, 0);
            r.rdata = cur_write ? 32'd0 : bus_rData;
            r.error = bus_error;
            r.last  = (beats_done == int'(cur_len)) || bus_error;
            exp_rsp.push_back(r);
            addr_log.push_back(bus_addr);
            void'(exp_beats.pop_front());
            beats_done++;
            if (bus_error) begin errored = 1; exp_beats.delete(); end
          end
        end
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_rsp.size() == 0) chk("rsp_spurious", 1, 0);
        else begin
          e = exp_rsp.pop_front();
          chk("rsp_rdata", rsp_rData, e.rdata);
          chk("rsp_err_last", {rsp_error, rsp_last}, {e.error, e.last});
          rsp_cnt++;
          if (rsp_last) last_cnt++;
          last_err = rsp_error;
          if (e.last) txn_open = 0;
        end
      end
    end
  end

  task automatic start_cmd(input logic w, input logic [31:0] a, input logic [1:0] bt,
                           input logic [7:0] len, input int eb);
    beat_t b;
    int    n;
    bit    got;
    cur_write = w; cur_bt = bt; cur_len = len;
    cur_ns = 1'($urandom); cur_prot = 4'($urandom);
    err_beat = eb;
    n = (eb >= 0 && eb <= int'(len)) ? eb + 1 : int'(len) + 1;
    wr_plan.delete();
    for (int i = 0; i < n; i++) begin
      b.addr  = model_addr(a, bt, len, i);
      b.wdata = wdata_fixed ? 32'h12345678 : $urandom;
      b.wstrb = wdata_fixed ? 4'hF : 4'($urandom);
      exp_beats.push_back(b);
      wr_plan.push_back(b);
    end
    cmd_write = w; cmd_addr = a; cmd_burstType = bt; cmd_burstLen = len;
    cmd_nonSec = cur_ns; cmd_prot = cur_prot; cmd_valid = 1;
    got = 0;
    for (int k = 0; k < 500 && !got; k++) begin @(negedge clk); got = cmd_ready; end
    if (!got) chk("cmd_timeout", 1, 0);
    @(posedge clk); #1;
    cmd_valid = 0; cmd_addr = $urandom; cmd_burstLen = 8'($urandom);
  endtask

  task automatic drive_writes();
    bit got;
    foreach (wr_plan[i]) begin
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      wr_valid = 1; wr_data = wr_plan[i].wdata; wr_strb = wr_plan[i].wstrb;
      got = 0;
      for (int k = 0; k < 500 && !got; k++) begin @(negedge clk); got = wr_ready; end
      if (!got) begin chk("wr_timeout", 1, 0); wr_valid = 0; return; end
      @(posedge clk); #1;
      wr_valid = 0; wr_data = $urandom;
    end
  endtask

  task automatic wait_done();
    bit fin;
    fin = 0;
    for (int k = 0; k < 3000 && !fin; k++) begin @(negedge clk); fin = !txn_open; end
    if (!fin) chk("txn_timeout", 1, 0);
    @(posedge clk); #1;
  endtask

  task automatic run_txn(input logic w, input logic [31:0] a, input logic [1:0] bt,
                         input logic [7:0] len, input int eb);
    start_cmd(w, a, bt, len, eb);
    if (w) drive_writes();
    // After an error the requester keeps offering data; none may be taken.
    if (w && eb >= 0 && eb <= int'(len)) begin wr_valid = 1; wr_data = $urandom; end
    wait_done();
    wr_valid = 0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ctrl"}, {cmd_ready, wr_ready, rsp_valid, rsp_error, rsp_last, bus_wEn, bus_rEn,
                         bus_isBurst, bus_burstType, bus_burstLen, bus_nonSec, bus_prot}, 0);
    chk({tag, "_addr_rdata"}, {rsp_rData, bus_addr}, 0);
    chk({tag, "_wdata"}, {bus_wData, bus_wStrb}, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [7:0]  len;
    int          eb;
    reset = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_burstType = 0;
    cmd_burstLen = 0; cmd_nonSec = 0; cmd_prot = 0; wr_valid = 0; wr_data = 0; wr_strb = 0;
    repeat (3) @(posedge clk);
    #1 check_all_zero("reset");
    chk("model_wrap", model_addr(32'h38, 2'd2, 8'd3, 2), 32'h30);
    chk("model_incr_mod", model_addr(32'hFFFFFFFC, 2'd1, 8'd1, 1), 32'h0);
    reset = 0;
    @(negedge clk) chk("cmd_ready_after_reset", cmd_ready, 1);
    @(posedge clk); #1;

    // Single read with exact latency.
    busy_mode = 0; rdy_mode = 1; rdata_fixed = 1; rdata_fix = 32'hDEADBEEF;
    start_cmd(0, 32'h100, 2'd1, 8'd0, -1);
    @(negedge clk) chk("rd_no_en_n1", bus_rEn, 0);
    @(negedge clk) chk("rd_en_n2", {bus_rEn, bus_addr}, {1'b1, 32'h100});
    @(negedge clk) chk("rd_rsp_n3", {bus_rEn, rsp_valid, rsp_rData, rsp_last, rsp_error},
                       {1'b0, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0});
    wait_done();
    rdata_fixed = 0;

    // Single write held over two busy cycles.
    busy_mode = 2; wdata_fixed = 1; en_cycles = 0; rsp_cnt = 0; last_cnt = 0;
    run_txn(1, 32'h104, 2'd1, 8'd0, -1);
    chk("wr_en_cycles", en_cycles, 3);
    chk("wr_rsp", {rsp_cnt[7:0], last_cnt[7:0], last_err}, {8'd1, 8'd1, 1'b0});
    wdata_fixed = 0;

    // INCR4, WRAP4 and FIXED reads.
    busy_mode = 1; rdy_mode = 2; rsp_cnt = 0; last_cnt = 0; addr_log.delete();
    run_txn(0, 32'h200, 2'd1, 8'd3, -1);
    chk("incr4_addrs", {addr_log[0], addr_log[1]}, {32'h200, 32'h204});
    chk("incr4_addrs_hi", {addr_log[2], addr_log[3]}, {32'h208, 32'h20C});
    chk("incr4_rsp", {rsp_cnt[7:0], last_cnt[7:0]}, {8'd4, 8'd1});
    addr_log.delete();
    run_txn(0, 32'h38, 2'd2, 8'd3, -1);
    run_txn(0, 32'h40, 2'd0, 8'd2, -1);
    chk("wrap4_addrs", {addr_log[0], addr_log[1]}, {32'h38, 32'h3C});
    chk("wrap4_addrs_hi", {addr_log[2], addr_log[3]}, {32'h30, 32'h34});
    chk("fixed_addrs", {addr_log[4], addr_log[5], addr_log[6][15:0]}, {32'h40, 32'h40, 16'h40});

    // INCR4 write terminated by an error on the second beat.
    rsp_cnt = 0; addr_log.delete();
    run_txn(1, 32'h300, 2'd1, 8'd3, 1);
    chk("err_rsp", {rsp_cnt[7:0], last_err, addr_log.size() == 2}, {8'd2, 1'b1, 1'b1});

    // Response stall, then reset in the middle of the burst.
    busy_mode = 0; rdy_mode = 0; rsp_cnt = 0;
    start_cmd(0, 32'h200, 2'd1, 8'd3, -1);
    repeat (5) @(posedge clk);
    #1 chk("stall_one_beat", {beats_done[7:0], rsp_valid, bus_rEn}, {8'd1, 1'b1, 1'b0});
    rdy_mode = 1;
    for (int k = 0; k < 100 && beats_done < 3; k++) @(negedge clk);
    chk("stall_resume", beats_done >= 3, 1);
    @(posedge clk); #3 reset = 1;
    #1 check_all_zero("midreset");
    @(posedge clk); #1 reset = 0;
    @(negedge clk) chk("cmd_ready_after_midreset", cmd_ready, 1);
    chk("stall_rsp_seen", rsp_cnt >= 2, 1);
    @(posedge clk); #1;
    run_txn(0, 32'h80, 2'd1, 8'd1, -1);

    // Randomized traffic.
    busy_mode = 1; rdy_mode = 2;
    for (int t = 0; t < 60; t++) begin
      case ($urandom_range(0, 4))
        0: len = 8'd0;
        1: len = 8'd1;
        2: len = 8'd3;
        3: len = 8'd7;
        default: len = 8'($urandom_range(0, 20));
      endcase
      a  = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFF8 : ($urandom & 32'hFFFF_FFFC);
      eb = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, int'(len))) : -1;
      run_txn(1'($urandom), a, 2'($urandom), len, eb);
    end

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
